// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the multi-cycle MIPS core. Owns the program
// counter, issues single-word requests to instruction memory, latches the
// returned word into the instruction register and hands it to the opcode
// decoder through a valid/ready handshake. Branch/jump redirects are accepted
// in every state; accepted instructions are counted.
//
// Optional feature (compile-time macro IFU_TIMEOUT_EN):
//   defined   - a response that fails to arrive within TIMEOUT_CYCLES WAIT
//               cycles sets the sticky fetch_err flag and the request is
//               reissued (to the pending redirect target if one is stored).
//   undefined - WAIT waits indefinitely and fetch_err is tied to 0.
//
// Parameters:
//   RESET_PC        PC after reset (word aligned)
//   TIMEOUT_CYCLES  WAIT cycles before a timeout (IFU_TIMEOUT_EN only)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req / imem_addr         one-cycle fetch request and its address
//   imem_rvalid / imem_rdata     instruction memory response
//   redirect_valid / redirect_pc branch/jump redirect (target bits [1:0] dropped)
//   instr / opcode               instruction register and its opcode field
//   pc_out / pc_plus4            address of instr and that address + 4
//   instr_valid / instr_ready    decoder handshake
//   fetch_count                  accepted-instruction counter (wraps)
//   fetch_err                    sticky timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] fetch_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Reject misaligned reset PCs and meaningless timeouts at elaboration.
    if (TIMEOUT_CYCLES < 1 || RESET_PC[1:0] != 2'b00) begin : g_cfg_check
        $error("instr_fetch_unit: invalid RESET_PC or TIMEOUT_CYCLES");
    end

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic [15:0] r_fetch_count;
    logic        r_redir_pend;
    logic [31:0] r_redir_tgt;

    logic [31:0] w_redir_tgt;
    logic        w_pend_any;
    logic [31:0] w_pend_tgt;
    logic [31:0] w_pc_inc;
    logic        w_unused;

    assign w_redir_tgt = {redirect_pc[31:2], 2'b00};
    assign w_unused    = &{1'b0, redirect_pc[1:0]};
    // A redirect arriving in the same cycle as the response (or timeout)
    // takes precedence over a previously stored one.
    assign w_pend_any  = r_redir_pend | redirect_valid;
    assign w_pend_tgt  = redirect_valid ? w_redir_tgt : r_redir_tgt;
    assign w_pc_inc    = r_pc + 32'd4;

`ifdef IFU_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_fetch_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_pc_out      <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fetch_count <= 16'd0;
            r_redir_pend  <= 1'b0;
            r_redir_tgt   <= 32'd0;
`ifdef IFU_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) r_pc <= w_redir_tgt;
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    r_imem_req <= 1'b0;
                    r_state    <= S_WAIT;
                    if (redirect_valid) begin
                        r_redir_pend <= 1'b1;
                        r_redir_tgt  <= w_redir_tgt;
                    end
`ifdef IFU_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (w_pend_any) begin
                            // Stale response: drop it and fetch the target.
                            r_pc         <= w_pend_tgt;
                            r_redir_pend <= 1'b0;
                            r_state      <= S_FETCH;
                            r_imem_req   <= 1'b1;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_pc_out      <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end else begin
                        if (redirect_valid) begin
                            r_redir_pend <= 1'b1;
                            r_redir_tgt  <= w_redir_tgt;
                        end
`ifdef IFU_TIMEOUT_EN
                        if (r_to_cnt == TO_LAST) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_FETCH;
                            r_imem_req  <= 1'b1;
                            if (w_pend_any) begin
                                r_pc         <= w_pend_tgt;
                                r_redir_pend <= 1'b0;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
`endif
                    end
                end
                S_HOLD: begin
                    // Either acceptance or a flush ends the hold; a redirect
                    // wins the next PC even when the instruction is accepted.
                    if (redirect_valid || instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_pc          <= redirect_valid ? w_redir_tgt : w_pc_inc;
                        if (instr_ready) r_fetch_count <= r_fetch_count + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_out + 32'd4;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;
`ifdef IFU_TIMEOUT_EN
    assign fetch_err   = r_fetch_err;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule
